// File: rtl/pool_engine_if.sv
// pool_engine_if: memory read/write request bundle of the pooling engine.
// master = engine side, slave = memory arbiter side.
interface pool_engine_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_W     = 8
);
  logic                  mem_rd_req;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_gnt;
  logic                  mem_rd_valid;
  logic [DATA_W-1:0]     mem_rd_data;
  logic                  mem_wr_req;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_W-1:0]     mem_wr_data;
  logic                  mem_wr_gnt;

  modport master (
    output mem_rd_req, mem_rd_addr,
    input  mem_rd_gnt, mem_rd_valid, mem_rd_data,
    output mem_wr_req, mem_wr_addr, mem_wr_data,
    input  mem_wr_gnt
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr,
    output mem_rd_gnt, mem_rd_valid, mem_rd_data,
    input  mem_wr_req, mem_wr_addr, mem_wr_data,
    output mem_wr_gnt
  );
endinterface

// File: rtl/pool_engine.sv
// pool_engine: 2^K x 2^K max/avg pooling of a signed byte matrix.
// One read outstanding, one write at a time, stride equals window.
module pool_engine #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_W     = 8,
  parameter int DIM_W      = 8,
  parameter int MAX_K_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_pool_start,
  input  logic [ADDR_WIDTH-1:0] sw_pool_rd_addr,
  input  logic [ADDR_WIDTH-1:0] sw_pool_wr_addr,
  input  logic [DIM_W-1:0]      sw_pool_rd_m,
  input  logic [DIM_W-1:0]      sw_pool_rd_n,
  input  logic [1:0]            sw_pool_k_log2,
  input  logic                  sw_pool_mode,
  output logic                  pool_sw_busy_ind,
  output logic                  pool_sw_done,
  output logic                  pool_sw_err,
  pool_engine_if.master         mem
);

  localparam int ACC_W = DATA_W + 2 * MAX_K_LOG2;
  localparam int IW    = MAX_K_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] rd_base_q;
  logic [ADDR_WIDTH-1:0] wr_base_q;
  logic [DIM_W-1:0]      n_q;
  logic [DIM_W-1:0]      om_q;
  logic [DIM_W-1:0]      on_q;
  logic [1:0]            k_q;
  logic                  mode_q;
  logic [DIM_W-1:0]      r_q;
  logic [DIM_W-1:0]      c_q;
  logic [IW-1:0]         i_q;
  logic [IW-1:0]         j_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                  err_q;

  logic [IW-1:0]         side_m1;
  logic                  bad;
  logic                  first;
  logic                  last_elem;
  logic                  last_out;
  logic signed [ACC_W-1:0] d_ext;
  logic [ADDR_WIDTH-1:0] row_a;
  logic [ADDR_WIDTH-1:0] col_a;
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;

  assign side_m1   = IW'((32'd1 << k_q) - 32'd1);
  assign bad       = (int'(k_q) > MAX_K_LOG2) ||
                     (om_q == '0) || (on_q == '0);
  assign first     = (i_q == '0) && (j_q == '0);
  assign last_elem = (i_q == side_m1) && (j_q == side_m1);
  assign last_out  = (r_q == om_q - DIM_W'(1)) &&
                     (c_q == on_q - DIM_W'(1));
  assign d_ext     = {{(ACC_W-DATA_W){mem.mem_rd_data[DATA_W-1]}},
                      mem.mem_rd_data};
  assign pool_sw_err = err_q;

  // element and result addresses from the window/output counters
  always_comb begin
    row_a     = (ADDR_WIDTH'(r_q) << k_q) + ADDR_WIDTH'(i_q);
    col_a     = (ADDR_WIDTH'(c_q) << k_q) + ADDR_WIDTH'(j_q);
    rd_addr_c = rd_base_q + row_a * ADDR_WIDTH'(n_q) + col_a;
    wr_addr_c = wr_base_q + ADDR_WIDTH'(r_q) * ADDR_WIDTH'(on_q)
              + ADDR_WIDTH'(c_q);
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (sw_pool_start) state_d = S_CHECK;
      S_CHECK:   state_d = bad ? S_DONE : S_RD_REQ;
      S_RD_REQ:  if (mem.mem_rd_gnt) state_d = S_RD_WAIT;
      S_RD_WAIT: if (mem.mem_rd_valid)
                   state_d = last_elem ? S_WR_REQ : S_RD_REQ;
      S_WR_REQ:  if (mem.mem_wr_gnt)
                   state_d = last_out ? S_DONE : S_RD_REQ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // outputs decoded from state; all zero outside their owning state
  always_comb begin
    pool_sw_busy_ind = 1'b0;
    pool_sw_done     = 1'b0;
    mem.mem_rd_req   = 1'b0;
    mem.mem_rd_addr  = '0;
    mem.mem_wr_req   = 1'b0;
    mem.mem_wr_addr  = '0;
    mem.mem_wr_data  = '0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_CHECK: pool_sw_busy_ind = 1'b1;
      S_RD_REQ: begin
        pool_sw_busy_ind = 1'b1;
        mem.mem_rd_req   = 1'b1;
        mem.mem_rd_addr  = rd_addr_c;
      end
      S_RD_WAIT: pool_sw_busy_ind = 1'b1;
      S_WR_REQ: begin
        pool_sw_busy_ind = 1'b1;
        mem.mem_wr_req   = 1'b1;
        mem.mem_wr_addr  = wr_addr_c;
        mem.mem_wr_data  = mode_q ?
                           DATA_W'(acc_q >>> {k_q, 1'b0}) :
                           DATA_W'(acc_q);
      end
      S_DONE: begin
        pool_sw_busy_ind = 1'b1;
        pool_sw_done     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // config capture, window/output counters, accumulator, sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_base_q <= '0;
      wr_base_q <= '0;
      n_q       <= '0;
      om_q      <= '0;
      on_q      <= '0;
      k_q       <= '0;
      mode_q    <= 1'b0;
      r_q       <= '0;
      c_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && sw_pool_start) begin
        rd_base_q <= sw_pool_rd_addr;
        wr_base_q <= sw_pool_wr_addr;
        n_q       <= sw_pool_rd_n;
        om_q      <= sw_pool_rd_m >> sw_pool_k_log2;
        on_q      <= sw_pool_rd_n >> sw_pool_k_log2;
        k_q       <= sw_pool_k_log2;
        mode_q    <= sw_pool_mode;
        r_q       <= '0;
        c_q       <= '0;
        i_q       <= '0;
        j_q       <= '0;
        acc_q     <= '0;
        err_q     <= 1'b0;
      end
      if (state_q == S_CHECK && bad) err_q <= 1'b1;
      if (state_q == S_RD_WAIT && mem.mem_rd_valid) begin
        if (first)
          acc_q <= d_ext;
        else if (mode_q)
          acc_q <= acc_q + d_ext;
        else if (d_ext > acc_q)
          acc_q <= d_ext;
        if (j_q == side_m1) begin
          j_q <= '0;
          i_q <= (i_q == side_m1) ? '0 : i_q + IW'(1);
        end else begin
          j_q <= j_q + IW'(1);
        end
      end
      if (state_q == S_WR_REQ && mem.mem_wr_gnt) begin
        if (c_q == on_q - DIM_W'(1)) begin
          c_q <= '0;
          r_q <= r_q + DIM_W'(1);
        end else begin
          c_q <= c_q + DIM_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: pooling jobs checked against a behavioural model.
// A memory responder with random stalls checks every handshake.
module tb_pool_engine;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int BOUND = 6000;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          start    = 1'b0;
  logic [AW-1:0] cfg_rb   = '0;
  logic [AW-1:0] cfg_wb   = '0;
  logic [7:0]    cfg_m    = '0;
  logic [7:0]    cfg_n    = '0;
  logic [1:0]    cfg_k    = '0;
  logic          cfg_mode = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  pool_engine_if #(.ADDR_WIDTH(AW), .DATA_W(DW)) mif ();

  pool_engine #(
    .ADDR_WIDTH(AW), .DATA_W(DW), .DIM_W(8), .MAX_K_LOG2(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_pool_start(start),
    .sw_pool_rd_addr(cfg_rb),
    .sw_pool_wr_addr(cfg_wb),
    .sw_pool_rd_m(cfg_m),
    .sw_pool_rd_n(cfg_n),
    .sw_pool_k_log2(cfg_k),
    .sw_pool_mode(cfg_mode),
    .pool_sw_busy_ind(busy),
    .pool_sw_done(done),
    .pool_sw_err(err),
    .mem(mif)
  );

  logic [7:0]    mem [4096];
  logic [AW-1:0] exp_rd [$];
  logic [AW-1:0] exp_wa [$];
  logic [7:0]    exp_wd [$];

  int tests = 0;
  int fails = 0;
  bit stall_en = 1'b0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int req_cnt = 0;
  int rd_gnt_cnt = 0;
  int vcnt = 0;
  int rd_stall = 0;
  int wr_stall = 0;
  logic [7:0] vdata = '0;
  bit rd_hold = 1'b0;
  bit wr_hold = 1'b0;
  logic [AW-1:0] rd_hold_a = '0;
  logic [AW-1:0] wr_hold_a = '0;
  logic [7:0]    wr_hold_d = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  // expected read sequence and writes, straight from the pooling rules
  function automatic bit build_model(input logic [AW-1:0] rb,
      input logic [AW-1:0] wb, input int mm, input int nn,
      input int kk, input bit md);
    int s, om, on, sum, mx, a, res;
    byte v;
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    if (kk > 2) return 1'b0;
    s  = 1 << kk;
    om = mm / s;
    on = nn / s;
    if (om == 0 || on == 0) return 1'b0;
    for (int r = 0; r < om; r++) begin
      for (int c = 0; c < on; c++) begin
        sum = 0;
        mx  = -1000;
        for (int i = 0; i < s; i++) begin
          for (int j = 0; j < s; j++) begin
            a = (int'(rb) + (r * s + i) * nn + c * s + j) % 4096;
            exp_rd.push_back(a[AW-1:0]);
            v = mem[a];
            sum += int'(v);
            if (int'(v) > mx) mx = int'(v);
          end
        end
        res = md ? floor_div(sum, s * s) : mx;
        a = (int'(wb) + r * on + c) % 4096;
        exp_wa.push_back(a[AW-1:0]);
        exp_wd.push_back(res[7:0]);
      end
    end
    return 1'b1;
  endfunction

  // memory responder and handshake checker
  always @(negedge clk) begin
    mif.mem_rd_gnt   = 1'b0;
    mif.mem_rd_valid = 1'b0;
    mif.mem_wr_gnt   = 1'b0;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (vcnt > 0) begin
      vcnt--;
      if (vcnt == 0) begin
        mif.mem_rd_valid = 1'b1;
        mif.mem_rd_data  = vdata;
      end
    end
    if (rd_hold) begin
      chk("rd_req_held", 32'(mif.mem_rd_req), 1);
      chk("rd_addr_stable", 32'(mif.mem_rd_addr), 32'(rd_hold_a));
    end
    rd_hold = 1'b0;
    if (mif.mem_rd_req) begin
      req_cnt++;
      if (rd_stall == 0) begin
        mif.mem_rd_gnt = 1'b1;
        rd_gnt_cnt++;
        chk("rd_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0)
          chk("rd_addr", 32'(mif.mem_rd_addr), 32'(exp_rd.pop_front()));
        vdata    = mem[mif.mem_rd_addr];
        vcnt     = stall_en ? int'($urandom_range(1, 4)) : 1;
        rd_stall = stall_en ? int'($urandom_range(0, 5)) : 0;
      end else begin
        rd_stall--;
        rd_hold   = 1'b1;
        rd_hold_a = mif.mem_rd_addr;
      end
    end
    if (wr_hold) begin
      chk("wr_req_held", 32'(mif.mem_wr_req), 1);
      chk("wr_addr_stable", 32'(mif.mem_wr_addr), 32'(wr_hold_a));
      chk("wr_data_stable", 32'(mif.mem_wr_data), 32'(wr_hold_d));
    end
    wr_hold = 1'b0;
    if (mif.mem_wr_req) begin
      req_cnt++;
      if (wr_stall == 0) begin
        mif.mem_wr_gnt = 1'b1;
        chk("wr_expected", 32'(exp_wa.size() != 0), 1);
        if (exp_wa.size() != 0) begin
          chk("wr_addr", 32'(mif.mem_wr_addr), 32'(exp_wa.pop_front()));
          chk("wr_data", 32'(mif.mem_wr_data), 32'(exp_wd.pop_front()));
        end
        wr_stall = stall_en ? int'($urandom_range(0, 5)) : 0;
      end else begin
        wr_stall--;
        wr_hold   = 1'b1;
        wr_hold_a = mif.mem_wr_addr;
        wr_hold_d = mif.mem_wr_data;
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rd_req"}, 32'(mif.mem_rd_req), 0);
    chk({tag, "_rd_addr"}, 32'(mif.mem_rd_addr), 0);
    chk({tag, "_wr_req"}, 32'(mif.mem_wr_req), 0);
    chk({tag, "_wr_addr"}, 32'(mif.mem_wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(mif.mem_wr_data), 0);
  endtask

  task automatic run_job(input logic [AW-1:0] rb, input logic [AW-1:0] wb,
      input int mm, input int nn, input int kk, input bit md,
      input bit stalls, input bit mid);
    bit ok;
    bit seen;
    int d0, b0, q0, s, lat;
    ok = build_model(rb, wb, mm, nn, kk, md);
    s = 1 << kk;
    lat = ok ? 2 + (mm / s) * (nn / s) * (2 * s * s + 1) : 2;
    stall_en = stalls;
    rd_stall = 0;
    wr_stall = 0;
    step();
    cfg_rb = rb; cfg_wb = wb;
    cfg_m = 8'(mm); cfg_n = 8'(nn);
    cfg_k = 2'(kk); cfg_mode = md;
    start = 1'b1;
    d0 = done_cnt; b0 = busy_cnt; q0 = req_cnt;
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    seen = 1'b0;
    for (int t = 0; t < BOUND; t++) begin
      if (done_cnt > d0) begin
        seen = 1'b1;
        break;
      end
      if (mid && t == 6 && busy) begin
        cfg_rb = '0; cfg_m = 8'd2; cfg_n = 8'd2;
        cfg_k = 2'd0; cfg_mode = ~md;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 1);
    step();
    chk("busy_after_done", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
    chk("done_once", 32'(done_cnt - d0), 1);
    chk("err", 32'(err), 32'(!ok));
    chk("rd_all_issued", 32'(exp_rd.size()), 0);
    chk("wr_all_issued", 32'(exp_wa.size()), 0);
    if (!ok) chk("no_mem_req", 32'(req_cnt - q0), 0);
    if (!stalls) chk("latency", 32'(busy_cnt - b0), 32'(lat));
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int pin_max [4] = '{5, 7, 13, 15};
    int pin_avg [4] = '{2, 4, 10, 12};
    int g0;
    logic [AW-1:0] rb, wb;
    mif.mem_rd_gnt   = 1'b0;
    mif.mem_rd_valid = 1'b0;
    mif.mem_rd_data  = '0;
    mif.mem_wr_gnt   = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    repeat (3) step();
    chk_quiet("reset");
    rst = 1'b0;
    step();

    for (int x = 0; x < 16; x++) mem[12'h100 + x] = 8'(x);
    ok = build_model(12'h100, 12'h200, 4, 4, 1, 1'b0);
    for (int x = 0; x < 4; x++) begin
      chk("model_max", 32'(exp_wd[x]), 32'(pin_max[x]));
      chk("model_wa", 32'(exp_wa[x]), 32'(12'h200 + x));
    end
    run_job(12'h100, 12'h200, 4, 4, 1, 1'b0, 1'b0, 1'b0);
    ok = build_model(12'h100, 12'h200, 4, 4, 1, 1'b1);
    for (int x = 0; x < 4; x++)
      chk("model_avg", 32'(exp_wd[x]), 32'(pin_avg[x]));
    run_job(12'h100, 12'h200, 4, 4, 1, 1'b1, 1'b0, 1'b0);

    mem[12'h300] = 8'hFF; mem[12'h301] = 8'hFE;
    mem[12'h302] = 8'hFD; mem[12'h303] = 8'hFC;
    ok = build_model(12'h300, 12'h210, 2, 2, 1, 1'b1);
    chk("model_neg_avg", 32'(exp_wd[0]), 32'h0FD);
    run_job(12'h300, 12'h210, 2, 2, 1, 1'b1, 1'b0, 1'b0);

    for (int x = 0; x < 35; x++) mem[12'h400 + x] = 8'(x * 7 - 60);
    ok = build_model(12'h400, 12'h200, 5, 7, 1, 1'b0);
    chk("model_5x7_reads", 32'(exp_rd.size()), 24);
    chk("model_5x7_lastrd", 32'(exp_rd[23]), 32'h41A);
    chk("model_5x7_lastwr", 32'(exp_wa[5]), 32'h205);
    run_job(12'h400, 12'h200, 5, 7, 1, 1'b0, 1'b0, 1'b0);
    run_job(12'h400, 12'h200, 5, 7, 1, 1'b1, 1'b1, 1'b1);

    run_job(12'h100, 12'h200, 4, 4, 3, 1'b0, 1'b0, 1'b0);
    step();
    chk("err_sticky", 32'(err), 1);
    run_job(12'h100, 12'h200, 1, 4, 1, 1'b1, 1'b0, 1'b0);
    run_job(12'h100, 12'h200, 4, 4, 0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      rb = (t == 0) ? 12'hFFA : AW'($urandom);
      wb = AW'($urandom);
      ok = build_model(rb, wb, 1, 1, 0, 1'b0);
      run_job(rb, wb, int'($urandom_range(1, 10)),
              int'($urandom_range(1, 10)),
              int'($urandom_range(0, 2)), 1'($urandom), 1'b0, 1'b0);
    end
    for (int t = 0; t < 10; t++) begin
      int mm, nn, kk;
      bit md;
      rb = AW'($urandom);
      wb = AW'($urandom);
      mm = int'($urandom_range(1, 10));
      nn = int'($urandom_range(1, 10));
      kk = int'($urandom_range(0, 2));
      md = 1'($urandom);
      run_job(rb, wb, mm, nn, kk, md, 1'b0, 1'b0);
      run_job(rb, wb, mm, nn, kk, md, 1'b1, 1'b1);
    end

    ok = build_model(12'h100, 12'h200, 4, 4, 1, 1'b0);
    stall_en = 1'b0;
    rd_stall = 0;
    wr_stall = 0;
    step();
    cfg_rb = 12'h100; cfg_wb = 12'h200;
    cfg_m = 8'd4; cfg_n = 8'd4; cfg_k = 2'd1; cfg_mode = 1'b0;
    g0 = rd_gnt_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 50 && rd_gnt_cnt == g0; t++) step();
    chk("rd_gnt_before_rst", 32'(rd_gnt_cnt > g0), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("midjob_rst");
    repeat (3) step();
    rst = 1'b0;
    repeat (6) step();
    chk_quiet("after_rst");
    run_job(12'h100, 12'h200, 4, 4, 1, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
